// File: rtl/rr_lock_arbiter.sv
// Round-robin arbiter with multi-beat transaction locking.
// Grant outputs are combinational; state advances only on an accepted beat.
module rr_lock_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = (NUM_REQ == 1) ? 1 : $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] IN_req,
    input  logic [NUM_REQ-1:0] IN_last,
    input  logic               IN_ready,
    output logic [NUM_REQ-1:0] OUT_grantOH,
    output logic [IDX_W-1:0]   OUT_grantIdx,
    output logic               OUT_grantValid,
    output logic               OUT_locked
);

    localparam logic ST_IDLE   = 1'b0;
    localparam logic ST_LOCKED = 1'b1;

    logic [IDX_W-1:0]   prio;
    logic [IDX_W-1:0]   lock_idx;
    logic               locked;

    logic [NUM_REQ-1:0] scan_oh;
    logic [IDX_W-1:0]   scan_idx;
    logic [NUM_REQ-1:0] lock_oh;
    logic               xfer;
    logic               xfer_last;
    logic [IDX_W-1:0]   prio_next;

    // Winner is the requester with the smallest wrapped distance from prio.
    always_comb begin
        int best_d;
        int d;
        best_d   = NUM_REQ;
        d        = 0;
        scan_oh  = '0;
        scan_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            d = i - int'(prio);
            if (d < 0) d = d + NUM_REQ;
            if (IN_req[i] && d < best_d) begin
                best_d   = d;
                scan_idx = IDX_W'(i);
            end
        end
        if (best_d < NUM_REQ) scan_oh = NUM_REQ'(1) << scan_idx;
    end

    assign lock_oh = NUM_REQ'(1) << lock_idx;

    always_comb begin
        if (locked == ST_LOCKED) begin
            OUT_grantOH    = lock_oh;
            OUT_grantIdx   = lock_idx;
            OUT_grantValid = |(lock_oh & IN_req);
        end else begin
            OUT_grantOH    = scan_oh;
            OUT_grantIdx   = scan_idx;
            OUT_grantValid = |IN_req;
        end
    end

    assign OUT_locked = locked;
    assign xfer       = OUT_grantValid && IN_ready;
    assign xfer_last  = |(OUT_grantOH & IN_last);
    // Explicit wrap keeps prio below NUM_REQ for non-power-of-two counts.
    assign prio_next  = (int'(OUT_grantIdx) == NUM_REQ - 1) ? '0 : OUT_grantIdx + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            prio     <= '0;
            locked   <= ST_IDLE;
            lock_idx <= '0;
        end else if (xfer) begin
            if (xfer_last) begin
                locked <= ST_IDLE;
                prio   <= prio_next;
            end else begin
                locked   <= ST_LOCKED;
                lock_idx <= OUT_grantIdx;
            end
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!rst) begin
            assert ($onehot0(OUT_grantOH))
                else $error("grant not zero/one-hot: %b", OUT_grantOH);
            assert (!OUT_grantValid || OUT_grantOH != '0)
                else $error("grantValid without grant");
            assert ((OUT_grantOH == '0) ? (OUT_grantIdx == '0)
                                        : (OUT_grantOH == (NUM_REQ'(1) << OUT_grantIdx)))
                else $error("grantIdx %0d disagrees with grantOH %b", OUT_grantIdx, OUT_grantOH);
            assert (int'(prio) < NUM_REQ) else $error("prio out of range: %0d", prio);
            assert (int'(lock_idx) < NUM_REQ) else $error("lockIdx out of range: %0d", lock_idx);
        end
    end
`endif

endmodule
